// File: rtl/ws2812_frame_scheduler.sv
// WS2812B frame scheduler: pixel store, frame timer, pixel stream and latch gap.
// Define WS2812_DOUBLE_BUF_EN for a front/back double-buffered pixel store.
module ws2812_frame_scheduler #(
  parameter int NUM_LEDS     = 2,
  parameter int FRAME_PERIOD = 1333333,
  parameter int LATCH_CYCLES = 4400,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  output logic          wr_ready,
  input  logic          commit,
  input  logic          auto_refresh,
  output logic          pix_valid,
  output logic [23:0]   pix_data,
  output logic          pix_last,
  input  logic          pix_ready,
  output logic          latch_active,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

`ifdef WS2812_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int DEPTH = NB * NUM_LEDS;
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(FRAME_PERIOD);
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [TW-1:0] TMAX = TW'(FRAME_PERIOD - 1);
  localparam logic [LW-1:0] LMAX = LW'(LATCH_CYCLES - 1);
  localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   NLED = (AW + 1)'(NUM_LEDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          pend_q, pend_d;
  logic          valid_q, valid_d;
  logic [23:0]   data_q, data_d;
  logic          last_q, last_d;
  logic          latch_q, latch_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  logic          tick;
  logic          start;
  logic          wr_acc;
  logic          wr_rdy;
  logic [RW-1:0] wr_base;
  logic [RW-1:0] rd_base;
  logic [RW-1:0] wr_idx;
  logic [RW-1:0] rd_idx;

  logic [23:0]   ram [DEPTH];

  assign tick = (timer_q == TMAX);

`ifdef WS2812_DOUBLE_BUF_EN
  logic front_q, front_d;
  logic rdy_q, rdy_d;

  // A commit in the same cycle as a swap targets the next frame, so it wins.
  always_comb begin
    front_d = front_q;
    rdy_d   = rdy_q;
    if (start) begin
      front_d = ~front_q;
      rdy_d   = 1'b1;
    end
    if (commit) begin
      rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      front_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      front_q <= front_d;
      rdy_q   <= rdy_d;
    end
  end

  assign wr_rdy  = rdy_q;
  assign wr_base = front_q ? '0 : RW'(NUM_LEDS);
  assign rd_base = front_q ? RW'(NUM_LEDS) : '0;
`else
  assign wr_rdy  = 1'b1;
  assign wr_base = '0;
  assign rd_base = '0;
`endif

  assign wr_acc = wr_en && wr_rdy && ({1'b0, wr_addr} < NLED);
  assign wr_idx = wr_base + RW'(wr_addr);
  assign rd_idx = rd_base + RW'(idx_q);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      ram[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick && (pend_q || auto_refresh)) begin
          start   = 1'b1;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (pix_ready) begin
          if (idx_q == LAST) begin
            lat_d   = '0;
            state_d = S_LATCH;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_LATCH: begin
        if (lat_q == LMAX) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so every port is a flop.
  always_comb begin
    timer_d = tick ? '0 : timer_q + TW'(1);
    pend_d  = pend_q;
    if (start) begin
      pend_d = 1'b0;
    end
    if (commit) begin
      pend_d = 1'b1;
    end
    data_d = data_q;
    last_d = last_q;
    if (state_q == S_LOAD) begin
      data_d = ram[rd_idx];
      last_d = (idx_q == LAST);
    end
    valid_d = (state_d == S_SEND);
    latch_d = (state_d == S_LATCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_LATCH) && (lat_d == LMAX);
    ovr_d   = ovr_q || (tick && (state_q != S_IDLE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign wr_ready     = wr_rdy;
  assign pix_valid    = valid_q;
  assign pix_data     = data_q;
  assign pix_last     = last_q;
  assign latch_active = latch_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed bench for ws2812_frame_scheduler (NUM_LEDS=2, FRAME_PERIOD=200, LATCH_CYCLES=20).
// Frames are table-driven; overrun and mid-frame reset are hand-written sequences.
module tb_ws2812_frame_scheduler;
  localparam int NL = 2;
  localparam int FP = 200;
  localparam int LC = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        auto_refresh = 1'b0;
  logic        pix_ready = 1'b0;
  logic        wr_ready;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        latch_active;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int passed = 0;
  int total = 0;
  int tcnt = 0;

  ws2812_frame_scheduler #(
    .NUM_LEDS(NL),
    .FRAME_PERIOD(FP),
    .LATCH_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .commit(commit),
    .auto_refresh(auto_refresh),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_last(pix_last),
    .pix_ready(pix_ready),
    .latch_active(latch_active),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference frame timer: tick when tcnt == FP-1
  always @(posedge clk) begin
    if (!rst_n) tcnt <= 0;
    else tcnt <= (tcnt == FP - 1) ? 0 : tcnt + 1;
  end

  typedef struct {
    logic [23:0] d0;
    logic [23:0] d1;
    int          stall;
    bit          cm;
    bit          au;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_pix_valid"}, 32'(pix_valid), 0);
    chk({nm, "_pix_data"}, 32'(pix_data), 0);
    chk({nm, "_pix_last"}, 32'(pix_last), 0);
    chk({nm, "_latch"}, 32'(latch_active), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_frame_done"}, 32'(frame_done), 0);
    chk({nm, "_overrun"}, 32'(overrun), 0);
    chk({nm, "_wr_ready"}, 32'(wr_ready), 1);
  endtask

  task automatic write_px(input logic a, input logic [23:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Move away from the tick so setup never straddles a frame start.
  task automatic sync();
    bit ok = 0;
    for (int i = 0; i <= FP + 5; i++) begin
      if (tcnt == 20) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("sync_wait", 32'(ok), 1);
  endtask

  task automatic prep(input logic [23:0] d0, input logic [23:0] d1,
                      input bit cm);
    write_px(1'b0, d0);
    write_px(1'b1, d1);
    if (cm) begin
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 0;
    for (int i = 0; i <= FP + 5; i++) begin
      if (tcnt == FP - 1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic play(input logic [23:0] d0, input logic [23:0] d1,
                      input int stall, input bit au);
    logic [23:0] ex [2];
    bit ok;
    bit stable;
    int lat_n, lat_first, done_n, done_at, busy_off, vbad;
    ex[0] = d0;
    ex[1] = d1;
    pix_ready = (stall == 0);
    auto_refresh = au;
    wait_tick(ok);
    chk("tick_wait", 32'(ok), 1);
    if (!ok) begin
      auto_refresh = 1'b0;
      return;
    end
    @(negedge clk);
    auto_refresh = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    chk("valid_at_T1", 32'(pix_valid), 0);
    chk("wr_ready_after_start", 32'(wr_ready), 1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("pix_valid", 32'(pix_valid), 1);
      chk("pix_data", 32'(pix_data), 32'(ex[i]));
      chk("pix_last", 32'(pix_last), (i == 1) ? 1 : 0);
      if (stall > 0) begin
        pix_ready = 1'b0;
        stable = 1;
        repeat (stall) begin
          @(negedge clk);
          if (pix_valid !== 1'b1 || pix_data !== ex[i]) stable = 0;
        end
        chk("stall_hold", 32'(stable), 1);
        pix_ready = 1'b1;
      end
      @(negedge clk);
      chk("bubble", 32'(pix_valid), 0);
      if (i == 0) @(negedge clk);
    end
    lat_n = 0; lat_first = 0; done_n = 0;
    done_at = 0; busy_off = 0; vbad = 0;
    for (int off = 1; off <= LC + 10; off++) begin
      if (latch_active) begin
        lat_n++;
        if (lat_first == 0) lat_first = off;
      end
      if (frame_done) begin
        done_n++;
        done_at = off;
      end
      if (!busy && busy_off == 0) busy_off = off;
      if (pix_valid) vbad++;
      @(negedge clk);
    end
    chk("latch_len", 32'(lat_n), LC);
    chk("latch_first", 32'(lat_first), 1);
    chk("done_count", 32'(done_n), 1);
    chk("done_at", 32'(done_at), LC);
    chk("busy_fall", 32'(busy_off), LC + 1);
    chk("no_extra_pixel", 32'(vbad), 0);
    pix_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    bit ok;
    vecs[0] = '{24'hFF00FF, 24'h7F0081, 0, 1'b1, 1'b0};
    vecs[1] = '{24'h123456, 24'hABCDEF, 50, 1'b1, 1'b0};
    vecs[2] = '{24'h000001, 24'h800000, 0, 1'b0, 1'b1};
    vecs[3] = '{24'hFFFFFF, 24'h000000, 3, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (pix_valid || busy) bad++;
    end
    chk("idle_quiet", 32'(bad), 0);

    for (int v = 0; v < 4; v++) begin
      sync();
      prep(vecs[v].d0, vecs[v].d1, vecs[v].cm);
      play(vecs[v].d0, vecs[v].d1, vecs[v].stall, vecs[v].au);
    end

`ifdef WS2812_DOUBLE_BUF_EN
    sync();
    prep(24'hA0A0A0, 24'hA1A1A1, 1'b1);
    chk("wr_ready_low", 32'(wr_ready), 0);
    write_px(1'b0, 24'hB0B0B0);
    write_px(1'b1, 24'hB1B1B1);
    play(24'hA0A0A0, 24'hA1A1A1, 0, 1'b0);
`endif

    sync();
    prep(24'h0F0F0F, 24'hF0F0F0, 1'b1);
    play(24'h0F0F0F, 24'hF0F0F0, 300, 1'b0);
    chk("overrun_set", 32'(overrun), 1);
    repeat (250) @(negedge clk);
    chk("overrun_sticky", 32'(overrun), 1);

    sync();
    prep(24'h111111, 24'h222222, 1'b1);
    pix_ready = 1'b0;
    wait_tick(ok);
    chk("tick_before_reset", 32'(ok), 1);
    repeat (2) @(negedge clk);
    chk("send_before_reset", 32'(pix_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("midsend_reset");
    rst_n = 1'b1;
    sync();
    prep(24'h00FF00, 24'h0000FF, 1'b1);
    play(24'h00FF00, 24'h0000FF, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ws2812_frame_scheduler.md
# ws2812_frame_scheduler

Frame-level controller for the WS2812B output chain. It holds a per-LED GRB pixel store that the host can write and schedules frame refreshes on a fixed frame timer. It streams pixels one at a time to the bit serializer over a valid/ready handshake, then times the latch (reset) gap during which the serializer holds the line low. It sits between host/pattern logic and the bit-level serializer, and owns every frame-level decision.

## Interface
- `NUM_LEDS`, 2: number of LEDs in the chain; must be ≥1.
- `FRAME_PERIOD`, 1333333: frame timer period in clk cycles (60 Hz at 80 MHz); must be ≥2.
- `LATCH_CYCLES`, 4400: latch gap length in clk cycles (55 µs at 80 MHz); must be ≥1.
- `AW`, derived: `max(1, $clog2(NUM_LEDS))`; not user-set.

Ports:
- `clk`  in  1  single system clock (80 MHz); all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  host pixel write strobe; accepted when `wr_en && wr_ready`.
- `wr_addr`  in  AW  LED index.
- `wr_data`  in  24  pixel, GRB order, bit 23 = G[7].
- `wr_ready`  out  1  back buffer writable.
- `commit`  in  1  one-cycle pulse: publish written pixels.
- `auto_refresh`  in  1  refresh every frame tick even without a commit.
- `pix_valid`  out  1  `pix_data` valid toward the serializer.
- `pix_data`  out  24  GRB word for the current LED.
- `pix_last`  out  1  qualifies the final LED of the frame.
- `pix_ready`  in  1  serializer accepts the word.
- `latch_active`  out  1  latch gap in progress; serializer holds the line low.
- `busy`  out  1  high from frame start through the end of the latch gap.
- `frame_done`  out  1  one-cycle pulse on the last latch cycle.
- `overrun`  out  1  sticky: a frame tick was missed.

## Operation
- Frame timer: free-running counter 0..FRAME_PERIOD-1 that wraps. `tick` is asserted when the count equals FRAME_PERIOD-1.
- States: IDLE → LOAD → SEND → (LOAD | LATCH) → IDLE.
- IDLE: on `tick`, start a frame if `start_pend` is set (registered, set by an accepted `commit`) or `auto_refresh` is high.
  - Starting a frame clears `start_pend`, performs the bank swap (see Configuration), sets pixel index = 0 and enters LOAD.
  - On `tick` with neither condition, stay in IDLE.
- LOAD: issue a synchronous RAM read of the front bank at the current index, then go to SEND.
- SEND: hold `pix_valid` high with `pix_data`/`pix_last` stable until `pix_ready`.
  - On handshake with index < NUM_LEDS-1: increment the index and go to LOAD.
  - On handshake with the last index: go to LATCH.
- LATCH: `latch_active` is high for exactly LATCH_CYCLES cycles. `frame_done` pulses on the final cycle, then the FSM goes to IDLE.
- Overrun: a `tick` in any state other than IDLE sets `overrun`, which stays set until reset. That tick does not start a frame.
- `commit` is registered into `start_pend`. A `commit` in the same cycle as a frame start applies to the next frame.
- Writes:
  - `wr_addr` ≥ NUM_LEDS is dropped silently.
  - Writes never target the bank being displayed (with `WS2812_DOUBLE_BUF_EN`).
- Reset (any state, mid-frame included):
  - FSM to IDLE; timer, index and `start_pend` cleared; front bank = bank 0.
  - `pix_valid`=0, `pix_data`=0, `pix_last`=0, `latch_active`=0, `busy`=0, `frame_done`=0, `overrun`=0, `wr_ready`=1.
  - RAM contents are not cleared.

## Timing
- Start latency: tick in cycle T → LOAD in T+1 → `pix_valid` high in T+2.
- Inter-pixel bubble: handshake in cycle H → `pix_valid` low in H+1, high with the next pixel in H+2.
- Last pixel handshake in cycle H → `latch_active` high over H+1..H+LATCH_CYCLES; `frame_done` in H+LATCH_CYCLES; IDLE in H+LATCH_CYCLES+1.
- `busy` rises with LOAD and falls after the `frame_done` cycle.
- All outputs are registered. No combinational path from `pix_ready` to `pix_valid`.

## Configuration
- `WS2812_DOUBLE_BUF_EN` defined:
  - Two banks. Host writes the back bank; the serializer reads the front bank.
  - An accepted `commit` drops `wr_ready` until the swap at the next frame start. `wr_en` while `wr_ready`=0 is discarded.
  - The swap is not copy-on-swap: the new back bank holds the previous front contents.
- Undefined:
  - Single bank; writes go directly to the displayed RAM, and tearing is permitted.
  - `wr_ready` is tied to 1. `commit` only sets `start_pend`.

## Test plan
- Bench parameters: NUM_LEDS=2, FRAME_PERIOD=200, LATCH_CYCLES=20.
- Reset then idle with no commit and `auto_refresh`=0 for 1000 cycles → `pix_valid` never asserts and `busy`=0 throughout.
- Write LED0=0xFF00FF and LED1=0x7F0081, then `commit`; `pix_ready` tied to 1 → `pix_valid` in tick+2 with 0xFF00FF, then 0x7F0081 with `pix_last`=1. `latch_active` is high for 20 cycles and `frame_done` pulses once.
- Serializer stalls `pix_ready` low for 50 cycles → `pix_data` is held stable throughout and no pixel is repeated or skipped.
- Stall `pix_ready` for 300 cycles → `overrun`=1 and it stays set until `rst_n`=0.
- Double-buffer build: commit frame A, write B during `wr_ready`=0 → B is discarded and frame A is displayed. After the swap, `wr_ready`=1.
- Assert `rst_n`=0 mid-SEND → next cycle all outputs are at reset values; a later commit produces a correct frame from index 0.
